tick_debounce: RTL and testbench

- Consumer of the periodic one-cycle enable strobe from the divider/enable generator.
- Samples a raw asynchronous push-button on strobe boundaries and filters contact bounce.
- Delivers a clean level plus single-cycle press/release pulses to the CPU step/run control logic.
- Sits between board I/O pins and the core control FSM; one instance per button.

---
 rtl/tick_debounce.sv | 171 +++++++++++++++++
 tb/tb_tick_debounce.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/tick_debounce.sv
// tick_debounce: strobe-paced push-button debouncer with press/release pulses.
// Optional auto-repeat of press_pulse while held: define TICK_DEBOUNCE_REPEAT_EN.
`default_nettype none

module tick_debounce #(
    parameter int STABLE_TICKS = 4,
    parameter int CNT_W        = 8,
    parameter int HOLD_TICKS   = 50,
    parameter int RPT_TICKS    = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_en,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse
);

    if (STABLE_TICKS < 1 || STABLE_TICKS > (2**CNT_W) - 1) begin : g_bad_stable
        $error("tick_debounce: STABLE_TICKS out of range for CNT_W");
    end
    if (HOLD_TICKS < 1 || RPT_TICKS < 1) begin : g_bad_repeat
        $error("tick_debounce: HOLD_TICKS and RPT_TICKS must be at least 1");
    end

    typedef enum logic [1:0] {
        S_RELEASED     = 2'd0,
        S_PRESS_PEND   = 2'd1,
        S_PRESSED      = 2'd2,
        S_RELEASE_PEND = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] ACCEPT_CNT = CNT_W'(STABLE_TICKS - 1);

    logic             sync1_q, sync2_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             accept_press;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            state_q   <= S_RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= btn_in;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Any disagreement in a pending state is a bounce: fall back without a pulse.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        level_d      = level_q;
        accept_press = 1'b0;
        release_d    = 1'b0;
        case (state_q)
            S_RELEASED: begin
                if (sync2_q) begin
                    state_d = S_PRESS_PEND;
                    cnt_d   = '0;
                end
            end
            S_PRESS_PEND: begin
                if (!sync2_q) begin
                    state_d = S_RELEASED;
                    cnt_d   = '0;
                end else if (clk_en) begin
                    if (cnt_q == ACCEPT_CNT) begin
                        state_d      = S_PRESSED;
                        cnt_d        = '0;
                        level_d      = 1'b1;
                        accept_press = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_PRESSED: begin
                if (!sync2_q) begin
                    state_d = S_RELEASE_PEND;
                    cnt_d   = '0;
                end
            end
            S_RELEASE_PEND: begin
                if (sync2_q) begin
                    state_d = S_PRESSED;
                    cnt_d   = '0;
                end else if (clk_en) begin
                    if (cnt_q == ACCEPT_CNT) begin
                        state_d   = S_RELEASED;
                        cnt_d     = '0;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_RELEASED;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

`ifdef TICK_DEBOUNCE_REPEAT_EN
    localparam int RPT_W = $clog2((HOLD_TICKS > RPT_TICKS ? HOLD_TICKS : RPT_TICKS) + 1);
    localparam logic [RPT_W-1:0] HOLD_LAST = RPT_W'(HOLD_TICKS - 1);
    localparam logic [RPT_W-1:0] RPT_LAST  = RPT_W'(RPT_TICKS - 1);

    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             armed_q, armed_d;
    logic             rpt_fire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rpt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            rpt_q   <= rpt_d;
            armed_q <= armed_d;
        end
    end

    // Initial hold period first, then the shorter repeat interval once armed.
    always_comb begin
        rpt_d    = rpt_q;
        armed_d  = armed_q;
        rpt_fire = 1'b0;
        if (state_q != S_PRESSED || !sync2_q) begin
            rpt_d   = '0;
            armed_d = 1'b0;
        end else if (clk_en) begin
            if (rpt_q == (armed_q ? RPT_LAST : HOLD_LAST)) begin
                rpt_d    = '0;
                armed_d  = 1'b1;
                rpt_fire = 1'b1;
            end else begin
                rpt_d = rpt_q + RPT_W'(1);
            end
        end
    end

    assign press_d = accept_press | rpt_fire;
`else
    assign press_d = accept_press;
`endif

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule

`default_nettype wire

// File: tb/tb_tick_debounce.sv
// Directed self-checking bench for tick_debounce (four parameterisations on one clock).
`default_nettype none

module tb_tick_debounce;

    logic clk = 1'b0;
    logic reset;
    logic clk_en;
    logic btn;

    logic a_lvl, a_prs, a_rel;
    logic o_lvl, o_prs, o_rel;
    logic z_lvl, z_prs, z_rel;
    logic r_lvl, r_prs, r_rel;

    int checks   = 0;
    int failures = 0;

    int   a_pn, a_pf, a_rn, a_rf, a_both;
    logic a_hist [0:127];
    int   o_pn, o_pf;
    int   z_any;
    int   r_pn;
    int   r_at [0:7];
    logic r_lvl_end;

    always #5 clk = ~clk;

    tick_debounce #(.STABLE_TICKS(4), .CNT_W(8)) u_a (
        .clk(clk), .reset(reset), .clk_en(clk_en), .btn_in(btn),
        .btn_level(a_lvl), .press_pulse(a_prs), .release_pulse(a_rel));

    tick_debounce #(.STABLE_TICKS(1), .CNT_W(8)) u_one (
        .clk(clk), .reset(reset), .clk_en(1'b1), .btn_in(btn),
        .btn_level(o_lvl), .press_pulse(o_prs), .release_pulse(o_rel));

    tick_debounce #(.STABLE_TICKS(1), .CNT_W(8)) u_off (
        .clk(clk), .reset(reset), .clk_en(1'b0), .btn_in(btn),
        .btn_level(z_lvl), .press_pulse(z_prs), .release_pulse(z_rel));

    tick_debounce #(.STABLE_TICKS(4), .CNT_W(8), .HOLD_TICKS(3), .RPT_TICKS(2)) u_rpt (
        .clk(clk), .reset(reset), .clk_en(clk_en), .btn_in(btn),
        .btn_level(r_lvl), .press_pulse(r_prs), .release_pulse(r_rel));

    task automatic step(input logic en);
        @(negedge clk);
        clk_en = en;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        btn    = 1'b0;
        clk_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) step(1'b0);
    endtask

    // Cycle k drives btn before edge k; clk_en strobes on every 5th cycle.
    task automatic run(input int n, input int glitch_k, input int drop_k);
        do_reset();
        a_pn = 0; a_pf = 0; a_rn = 0; a_rf = 0; a_both = 0;
        o_pn = 0; o_pf = 0; z_any = 0; r_pn = 0; r_lvl_end = 1'b0;
        for (int i = 0; i < 8; i++) r_at[i] = 0;
        for (int i = 0; i < 128; i++) a_hist[i] = 1'b0;
        for (int k = 1; k <= n; k++) begin
            if (drop_k != 0 && k >= drop_k) btn = 1'b0;
            else                            btn = (k == glitch_k) ? 1'b0 : 1'b1;
            step((k % 5) == 0);
            if (a_prs) begin a_pn++; if (a_pf == 0) a_pf = k; end
            if (a_rel) begin a_rn++; if (a_rf == 0) a_rf = k; end
            if (a_prs && a_rel) a_both++;
            a_hist[k] = a_lvl;
            if (o_prs) begin o_pn++; if (o_pf == 0) o_pf = k; end
            if (z_lvl || z_prs || z_rel) z_any++;
            if (r_prs) begin
                if (r_pn < 8) r_at[r_pn] = k;
                r_pn++;
            end
            r_lvl_end = r_lvl;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; btn = 1'b1; clk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (a_lvl !== 1'b0) begin failures++; $display("FAIL reset_init_level got=%b exp=0", a_lvl); end
        checks++; if (a_prs !== 1'b0) begin failures++; $display("FAIL reset_init_press got=%b exp=0", a_prs); end
        checks++; if (a_rel !== 1'b0) begin failures++; $display("FAIL reset_init_release got=%b exp=0", a_rel); end
        do_reset();
        btn = 1'b1;
        for (int k = 1; k <= 20; k++) step((k % 5) == 0);
        checks++; if (a_prs !== 1'b1) begin failures++; $display("FAIL reset_prepulse got=%b exp=1", a_prs); end
        reset = 1'b1;
        #1;
        checks++; if (a_prs !== 1'b0) begin failures++; $display("FAIL reset_async_press got=%b exp=0", a_prs); end
        checks++; if (a_lvl !== 1'b0) begin failures++; $display("FAIL reset_async_level got=%b exp=0", a_lvl); end
        checks++; if (o_lvl !== 1'b0) begin failures++; $display("FAIL reset_async_level_one got=%b exp=0", o_lvl); end
        @(negedge clk);
        reset = 1'b0;
        step(1'b1);
        step(1'b1);
        checks++; if (a_lvl !== 1'b0) begin failures++; $display("FAIL reset_release_level got=%b exp=0", a_lvl); end
        checks++; if (a_prs !== 1'b0) begin failures++; $display("FAIL reset_release_press got=%b exp=0", a_prs); end
    endtask

    task automatic test_clean_press();
        run(30, 0, 0);
        checks++; if (a_pn !== 1)  begin failures++; $display("FAIL press_count got=%0d exp=1", a_pn); end
        checks++; if (a_pf !== 20) begin failures++; $display("FAIL press_cycle got=%0d exp=20", a_pf); end
        checks++; if (a_hist[19] !== 1'b0) begin failures++; $display("FAIL press_level_before got=%b exp=0", a_hist[19]); end
        checks++; if (a_hist[20] !== 1'b1) begin failures++; $display("FAIL press_level_at got=%b exp=1", a_hist[20]); end
        checks++; if (a_rn !== 0)  begin failures++; $display("FAIL press_no_release got=%0d exp=0", a_rn); end
    endtask

    task automatic test_bounce();
        run(45, 12, 0);
        checks++; if (a_pn !== 1)  begin failures++; $display("FAIL bounce_count got=%0d exp=1", a_pn); end
        checks++; if (a_pf !== 35) begin failures++; $display("FAIL bounce_cycle got=%0d exp=35", a_pf); end
    endtask

    task automatic test_clean_release();
        run(60, 0, 31);
        checks++; if (a_pn !== 1)  begin failures++; $display("FAIL release_press_count got=%0d exp=1", a_pn); end
        checks++; if (a_rn !== 1)  begin failures++; $display("FAIL release_count got=%0d exp=1", a_rn); end
        checks++; if (a_rf !== 50) begin failures++; $display("FAIL release_cycle got=%0d exp=50", a_rf); end
        checks++; if (a_hist[49] !== 1'b1) begin failures++; $display("FAIL release_level_before got=%b exp=1", a_hist[49]); end
        checks++; if (a_hist[50] !== 1'b0) begin failures++; $display("FAIL release_level_at got=%b exp=0", a_hist[50]); end
        checks++; if (a_both !== 0) begin failures++; $display("FAIL release_overlap got=%0d exp=0", a_both); end
    endtask

    task automatic test_edge_params();
        run(30, 0, 0);
        checks++; if (o_pf !== 4) begin failures++; $display("FAIL st1_press_cycle got=%0d exp=4", o_pf); end
        checks++; if (o_pn !== 1) begin failures++; $display("FAIL st1_press_count got=%0d exp=1", o_pn); end
        checks++; if (z_any !== 0) begin failures++; $display("FAIL en_low_activity got=%0d exp=0", z_any); end
    endtask

    task automatic test_repeat();
        int exp_n;
        int exp_at [0:7];
        for (int i = 0; i < 8; i++) exp_at[i] = 0;
`ifdef TICK_DEBOUNCE_REPEAT_EN
        exp_n = 5;
        exp_at[0] = 20; exp_at[1] = 35; exp_at[2] = 45; exp_at[3] = 55; exp_at[4] = 65;
`else
        exp_n = 1;
        exp_at[0] = 20;
`endif
        run(70, 0, 0);
        checks++; if (r_pn !== exp_n) begin failures++; $display("FAIL repeat_count got=%0d exp=%0d", r_pn, exp_n); end
        for (int i = 0; i < exp_n; i++) begin
            checks++;
            if (r_at[i] !== exp_at[i]) begin
                failures++;
                $display("FAIL repeat_pulse_%0d got=%0d exp=%0d", i, r_at[i], exp_at[i]);
            end
        end
        checks++; if (r_lvl_end !== 1'b1) begin failures++; $display("FAIL repeat_level got=%b exp=1", r_lvl_end); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_clean_release();
        test_edge_params();
        test_repeat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
